// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - mode/state codes and configuration legality check for pulse_gen_prog
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        MODE_CONT   = 2'b00,
        MODE_BURST  = 2'b01,
        MODE_SINGLE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DELAY = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    // Fields arrive zero-extended to 32 bits so one function serves any CNT_W/BURST_W.
    function automatic logic cfg_legal(input mode_e m, input logic [31:0] p,
                                       input logic [31:0] w, input logic [31:0] n);
        case (m)
            MODE_CONT:   return (p >= 2) && (w >= 1) && (w < p);
            MODE_BURST:  return (p >= 2) && (w >= 1) && (w < p) && (n >= 1);
            MODE_SINGLE: return (w >= 1);
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pulse_gen_timer.sv
// rtl/pulse_gen_timer.sv - loadable up-counter wrapping at a terminal value, with terminal-count flag
module pulse_gen_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic [CNT_W-1:0] terminal,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    assign tc = (count == terminal);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/pulse_gen_prog.sv
// rtl/pulse_gen_prog.sv - programmable pulse train (continuous/burst/single-shot)
// Optional start-phase delay is compiled in with PULSE_GEN_PHASE_EN.
module pulse_gen_prog
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   period,
    input  logic [CNT_W-1:0]   width,
    input  logic [BURST_W-1:0] burst_len,
`ifdef PULSE_GEN_PHASE_EN
    input  logic [CNT_W-1:0]   phase,
`endif
    output logic               pulse_out,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    logic [1:0]         state;
    mode_e              mode_in;
    mode_e              sh_mode;
    logic [CNT_W-1:0]   sh_period;
    logic [CNT_W-1:0]   sh_width;
    logic [BURST_W-1:0] sh_left;
    logic [CNT_W-1:0]   term;
    logic [CNT_W-1:0]   cnt;
    logic               tc;
    logic               trig;
    logic               legal;
    logic               reload_ok;
    logic               err_armed;
`ifdef PULSE_GEN_PHASE_EN
    logic [CNT_W-1:0]   sh_phase;
`endif

    assign mode_in   = mode_e'(mode);
    assign legal     = cfg_legal(mode_in, 32'(period), 32'(width), 32'(burst_len));
    assign reload_ok = cfg_legal(MODE_CONT, 32'(period), 32'(width), 32'd1);
    assign trig      = (state == IDLE) && enable && ((mode_in == MODE_CONT) || start);
    assign busy      = (state != IDLE);

    // A single shot is one "period" of W cycles with no low tail.
    always_comb begin
        term = (sh_mode == MODE_SINGLE) ? sh_width - 1'b1 : sh_period - 1'b1;
`ifdef PULSE_GEN_PHASE_EN
        if (state == DELAY) term = sh_phase - 1'b1;
`endif
    end

    pulse_gen_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (trig),
        .load_val ('0),
        .en       (busy),
        .terminal (term),
        .count    (cnt),
        .tc       (tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sh_mode   <= MODE_CONT;
            sh_period <= '0;
            sh_width  <= '0;
            sh_left   <= '0;
            err_armed <= 1'b1;
            pulse_out <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
`ifdef PULSE_GEN_PHASE_EN
            sh_phase  <= '0;
`endif
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            if (!enable) err_armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (trig && legal) begin
                        sh_mode   <= mode_in;
                        sh_period <= period;
                        sh_width  <= width;
                        sh_left   <= burst_len;
`ifdef PULSE_GEN_PHASE_EN
                        sh_phase  <= phase;
                        if (phase != '0) begin
                            state     <= DELAY;
                            pulse_out <= 1'b0;
                        end else begin
                            state     <= RUN;
                            pulse_out <= 1'b1;
                        end
`else
                        state     <= RUN;
                        pulse_out <= 1'b1;
`endif
                    end else if (trig && ((mode_in != MODE_CONT) || err_armed)) begin
                        // Continuous retries every cycle while enabled, so it only reports once per enable edge.
                        cfg_err <= 1'b1;
                        if (mode_in == MODE_CONT) err_armed <= 1'b0;
                    end
                end
`ifdef PULSE_GEN_PHASE_EN
                DELAY: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (tc) begin
                        state     <= RUN;
                        pulse_out <= 1'b1;
                    end
                end
`endif
                RUN: begin
                    if (!tc) begin
                        pulse_out <= (cnt + 1'b1) < sh_width;
                    end else begin
                        pulse_out <= 1'b0;
                        state     <= IDLE;
                        case (sh_mode)
                            MODE_SINGLE: done <= 1'b1;
                            MODE_BURST: begin
                                if (sh_left == BURST_W'(1)) begin
                                    done <= 1'b1;
                                end else if (enable) begin
                                    state     <= RUN;
                                    pulse_out <= 1'b1;
                                    sh_left   <= sh_left - 1'b1;
                                end
                            end
                            default: begin
                                if (enable && reload_ok) begin
                                    state     <= RUN;
                                    pulse_out <= 1'b1;
                                    sh_period <= period;
                                    sh_width  <= width;
                                end else if (enable) begin
                                    cfg_err   <= 1'b1;
                                    err_armed <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pulse_gen_prog.md
Name: pulse_gen_prog

Overview:
- Programmable successor to the fixed-period pulse generator.
- Generates a registered pulse train with runtime period and high-width, in three modes: continuous, N-pulse burst, single-shot.
- Reports busy, done and configuration-error status.
- Sits between control/CSR logic and downstream timing consumers (strobes, sample enables, PWM-like triggers).

Parameters:
- CNT_W, 16, width of the period, width and phase fields.
- BURST_W, 8, width of the burst-length field.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level gate; continuous mode runs while high; low aborts burst at period end.
- start  in  1  trigger for burst/single-shot; sampled only in IDLE.
- mode  in  2  00 continuous, 01 burst, 10 single-shot, 11 reserved.
- period  in  CNT_W  total cycles per pulse period P.
- width  in  CNT_W  high cycles per pulse W.
- burst_len  in  BURST_W  pulses per burst N.
- pulse_out  out  1  registered pulse output.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle strobe on natural burst/single-shot completion.
- cfg_err  out  1  one-cycle strobe when a trigger is rejected for illegal config.

Behaviour:
- Reset (async, active-high): state=IDLE, counters=0, pulse_out=0, busy=0, done=0, cfg_err=0.
- Legal config:
  - mode!=11.
  - Single-shot: W>=1.
  - Continuous/burst: P>=2 and 1<=W<P.
  - Burst: also N>=1.
- Trigger:
  - Continuous: enable=1 in IDLE.
  - Burst/single-shot: start=1 and enable=1 in IDLE.
  - Trigger with illegal config: cfg_err=1 next cycle, stay IDLE.
  - Continuous with illegal config: cfg_err pulses once per enable rising edge, not every cycle.
- Config latch: mode/period/width/burst_len are latched into shadow registers on trigger. Continuous mode reloads the shadows at each period boundary (cnt==P-1), so changes never produce runt pulses; an illegal reload stops at the boundary with cfg_err.
- Latency: trigger sampled at edge k gives pulse_out=1 after edge k; no extra pipeline delay.
- States: IDLE -> RUN (period counter cnt 0..P-1).
  - pulse_out = (cnt < W), registered.
  - cnt wraps P-1 -> 0.
  - Burst counter decrements at each wrap.
- Single-shot: W high cycles, then IDLE; done=1 in the first IDLE cycle. No low tail.
- Burst: after the N-th period completes (cnt==P-1, remaining==1), go to IDLE and assert done=1.
- Continuous: runs while enable=1. When enable falls, finish the current period, then IDLE. No done. The pulse high phase is never truncated.
- Burst with enable falling mid-burst: finish the current period, then IDLE, no done (abort).
- start while busy: ignored. start in the same cycle done is high: accepted (back-to-back).
- mode/period changes while busy: no effect until the next latch point.
- reset mid-operation: immediate return to reset values, including pulse_out=0 asynchronously.
- Arithmetic: unsigned CNT_W compares; counters never overflow because of legality checks.

Optional Feature:
- Macro: PULSE_GEN_PHASE_EN.
- Defined:
  - Adds input phase [CNT_W-1:0] and state DELAY.
  - On trigger, if phase>0, hold pulse_out=0 and busy=1 for exactly `phase` cycles, then enter RUN.
  - Phase applies only to the first pulse.
  - enable falling during DELAY returns to IDLE with no pulse and no done.
- Undefined: no phase port or DELAY state; RUN is entered directly on trigger.

Decomposition:
- Package pulse_gen_pkg:
  - mode enum (MODE_CONT, MODE_BURST, MODE_SINGLE, MODE_RSVD).
  - state enum (IDLE, DELAY, RUN).
  - Legality-check function.
- One sub-module, pulse_gen_timer: loadable CNT_W up-counter with wrap at a terminal value and a terminal-count flag; used for the period counter and the phase delay.

Test Plan:
- Reset asserted mid-RUN (P=10, W=3) -> pulse_out, busy, done drop immediately; IDLE after release.
- Continuous, P=5, W=2, enable held 40 cycles -> 8 pulses, each 2 high / 3 low. Drop enable at cnt=0 -> current period completes, then busy=0, done never set.
- Burst, N=3, P=4, W=1, start pulse -> 3 pulses at cycles 1, 5, 9 after start; done=1 one cycle after the 12th RUN cycle; second start same cycle as done -> new burst starts immediately.
- Illegal configs (W=0; W=P=4; N=0; mode=11) with start -> cfg_err one cycle, pulse_out stays 0, busy 0.
- Single-shot, W=7 -> exactly 7 high cycles, done next cycle. start asserted again during busy -> ignored.
- With PULSE_GEN_PHASE_EN, phase=6, burst N=2, P=4, W=2 -> first high exactly 6 cycles after trigger edge; enable low during DELAY -> no pulse, no done.
